instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 5 +
 rtl/fetch_pc_register.sv | 22 ++
 rtl/instruction_fetch.sv | 87 ++++++++
 tb/tb_instruction_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: fetch state encoding and instruction size shared by the fetch unit.
package instruction_fetch_pkg;
    localparam int unsigned INSTRUCTION_BYTES = 4;
    typedef enum logic [2:0] {REQUEST, WAIT, HOLD, DISCARD, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_pc_register.sv
// fetch_pc_register: program counter with sequential increment and redirect load.
module fetch_pc_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        increment_i,
    input  logic        load_i,
    input  logic [31:0] load_address_i,
    output logic [31:0] pc_o
);
    logic [31:0] pc_q, pc_d;
    // a redirect always beats the sequential step
    always_comb pc_d = load_i ? load_address_i : increment_i ? pc_q + 32'(INSTRUCTION_BYTES) : pc_q;
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_VECTOR;
        else pc_q <= pc_d;
    end
    assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: one-outstanding-request fetch FSM with redirect handling.
// Define FETCH_TRAP_EN to send jump errors to TRAP_VECTOR instead of halting.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_request_valid,
    input  logic        mem_request_ready,
    output logic [31:0] mem_request_address,
    input  logic        mem_response_valid,
    input  logic [31:0] mem_response_data,
    output logic        instruction_valid,
    input  logic        instruction_ready,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    input  logic        redirect_error,
    output logic        halted
);
`ifdef FETCH_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    fetch_state_e state_q, state_d;
    logic         req_valid_q, inst_valid_q, halted_q;
    logic [31:0]  instruction_q, instruction_pc_q, pc;
    logic         jump_error, take_redirect, halt_now, consume, capture;
    logic [31:0]  target;
    assign jump_error    = redirect_valid & (redirect_error | (|redirect_address[1:0]));
    assign take_redirect = state_q != HALT && redirect_valid && (!jump_error || TRAP_EN);
    assign halt_now      = state_q != HALT && jump_error && !TRAP_EN;
    assign target        = jump_error ? TRAP_VECTOR : redirect_address;
    assign consume       = state_q == HOLD && inst_valid_q && instruction_ready;
    // any redirect, good or bad, kills the response arriving in the same cycle
    assign capture       = state_q == WAIT && mem_response_valid && !redirect_valid;
    fetch_pc_register #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
        .clk           (clk),
        .reset         (reset),
        .increment_i   (consume && !redirect_valid),
        .load_i        (take_redirect),
        .load_address_i(target),
        .pc_o          (pc)
    );
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQUEST: state_d = mem_request_ready ? (take_redirect ? DISCARD : WAIT) : REQUEST;
            WAIT:    state_d = take_redirect ? (mem_response_valid ? REQUEST : DISCARD)
                                             : (mem_response_valid ? HOLD : WAIT);
            HOLD:    state_d = (take_redirect || consume) ? REQUEST : HOLD;
            DISCARD: state_d = mem_response_valid ? REQUEST : DISCARD;
            default: state_d = HALT;
        endcase
        if (halt_now) state_d = HALT;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= REQUEST;
            req_valid_q      <= 1'b1;
            inst_valid_q     <= 1'b0;
            halted_q         <= 1'b0;
            instruction_q    <= 32'h0;
            instruction_pc_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= state_d == REQUEST;
            inst_valid_q <= state_d == HOLD;
            halted_q     <= state_d == HALT;
            if (capture) begin
                instruction_q    <= mem_response_data;
                instruction_pc_q <= pc;
            end
        end
    end
    assign mem_request_valid   = req_valid_q;
    assign mem_request_address = {pc[31:2], 2'b00};
    assign instruction_valid   = inst_valid_q;
    assign instruction         = instruction_q;
    assign instruction_pc      = instruction_pc_q;
    assign halted              = halted_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenario tests for instruction_fetch.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_request_valid;
    logic        mem_request_ready = 1'b1;
    logic [31:0] mem_request_address;
    logic        mem_response_valid = 1'b0;
    logic [31:0] mem_response_data = 32'h0;
    logic        instruction_valid;
    logic        instruction_ready = 1'b1;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_address = 32'h0;
    logic        redirect_error = 1'b0;
    logic        halted;
    int          total = 0;
    int          bad = 0;

    instruction_fetch dut (
        .clk                (clk),
        .reset              (reset),
        .mem_request_valid  (mem_request_valid),
        .mem_request_ready  (mem_request_ready),
        .mem_request_address(mem_request_address),
        .mem_response_valid (mem_response_valid),
        .mem_response_data  (mem_response_data),
        .instruction_valid  (instruction_valid),
        .instruction_ready  (instruction_ready),
        .instruction        (instruction),
        .instruction_pc     (instruction_pc),
        .redirect_valid     (redirect_valid),
        .redirect_address   (redirect_address),
        .redirect_error     (redirect_error),
        .halted             (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        total++; if (mem_request_valid !== 1'b1) begin bad++; $display("FAIL reset_req_valid got=%b exp=1", mem_request_valid); end
        total++; if (mem_request_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", mem_request_address); end
        total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b exp=0", instruction_valid); end
        total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_instruction got=%h exp=00000000", instruction); end
        total++; if (instruction_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got=%h exp=00000000", instruction_pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        reset = 1'b0;
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            total++; if (mem_request_valid !== 1'b1 || mem_request_address !== a) begin bad++; $display("FAIL seq_req%0d valid=%b addr=%h exp_addr=%h", i, mem_request_valid, mem_request_address, a); end
            tick;
            total++; if (mem_request_valid !== 1'b0 || instruction_valid !== 1'b0) begin bad++; $display("FAIL seq_wait%0d req=%b ivalid=%b exp 0/0", i, mem_request_valid, instruction_valid); end
            mem_response_valid = 1'b1;
            mem_response_data  = word_at(a);
            tick;
            mem_response_valid = 1'b0;
            total++; if (instruction_valid !== 1'b1 || instruction !== word_at(a) || instruction_pc !== a) begin bad++; $display("FAIL seq_inst%0d valid=%b inst=%h pc=%h exp inst=%h pc=%h", i, instruction_valid, instruction, instruction_pc, word_at(a), a); end
            tick;
        end
    endtask

    task automatic test_redirect_wait;
        tick;
        redirect_valid   = 1'b1;
        redirect_address = 32'h200;
        tick;
        redirect_valid = 1'b0;
        total++; if (mem_request_valid !== 1'b0 || instruction_valid !== 1'b0) begin bad++; $display("FAIL rw_discard req=%b ivalid=%b exp 0/0", mem_request_valid, instruction_valid); end
        mem_response_valid = 1'b1;
        mem_response_data  = word_at(32'hC);
        tick;
        mem_response_valid = 1'b0;
        total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL rw_dropped ivalid=%b exp=0", instruction_valid); end
        total++; if (mem_request_valid !== 1'b1 || mem_request_address !== 32'h200) begin bad++; $display("FAIL rw_next_req valid=%b addr=%h exp 1/00000200", mem_request_valid, mem_request_address); end
        tick;
        mem_response_valid = 1'b1;
        mem_response_data  = word_at(32'h200);
        tick;
        mem_response_valid = 1'b0;
        total++; if (instruction !== word_at(32'h200) || instruction_pc !== 32'h200) begin bad++; $display("FAIL rw_target inst=%h pc=%h exp %h/00000200", instruction, instruction_pc, word_at(32'h200)); end
        tick;
    endtask

    task automatic test_redirect_resp;
        tick;
        mem_response_valid = 1'b1;
        mem_response_data  = word_at(32'h204);
        redirect_valid     = 1'b1;
        redirect_address   = 32'h40;
        tick;
        mem_response_valid = 1'b0;
        redirect_valid     = 1'b0;
        total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL rr_no_inst ivalid=%b exp=0", instruction_valid); end
        total++; if (mem_request_valid !== 1'b1 || mem_request_address !== 32'h40) begin bad++; $display("FAIL rr_next_req valid=%b addr=%h exp 1/00000040", mem_request_valid, mem_request_address); end
    endtask

    task automatic test_stall;
        tick;
        instruction_ready  = 1'b0;
        mem_response_valid = 1'b1;
        mem_response_data  = word_at(32'h40);
        tick;
        mem_response_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (instruction_valid !== 1'b1 || instruction !== word_at(32'h40) || instruction_pc !== 32'h40 || mem_request_valid !== 1'b0) begin bad++; $display("FAIL stall%0d ivalid=%b inst=%h pc=%h req=%b exp 1/%h/00000040/0", i, instruction_valid, instruction, instruction_pc, mem_request_valid, word_at(32'h40)); end
            tick;
        end
        instruction_ready = 1'b1;
        tick;
        total++; if (instruction_valid !== 1'b0 || mem_request_address !== 32'h44) begin bad++; $display("FAIL stall_release ivalid=%b addr=%h exp 0/00000044", instruction_valid, mem_request_address); end
    endtask

    task automatic test_wrap;
        redirect_valid   = 1'b1;
        redirect_address = 32'hFFFF_FFFC;
        tick;
        redirect_valid = 1'b0;
        total++; if (mem_request_valid !== 1'b0) begin bad++; $display("FAIL wrap_inflight_discard req=%b exp=0", mem_request_valid); end
        mem_response_valid = 1'b1;
        mem_response_data  = word_at(32'h44);
        tick;
        mem_response_valid = 1'b0;
        total++; if (instruction_valid !== 1'b0 || mem_request_address !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req ivalid=%b addr=%h exp 0/fffffffc", instruction_valid, mem_request_address); end
        tick;
        mem_response_valid = 1'b1;
        mem_response_data  = word_at(32'hFFFF_FFFC);
        tick;
        mem_response_valid = 1'b0;
        total++; if (instruction_pc !== 32'hFFFF_FFFC || instruction !== word_at(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_inst pc=%h inst=%h exp fffffffc/%h", instruction_pc, instruction, word_at(32'hFFFF_FFFC)); end
        tick;
        total++; if (mem_request_valid !== 1'b1 || mem_request_address !== 32'h0) begin bad++; $display("FAIL wrap_zero valid=%b addr=%h exp 1/00000000", mem_request_valid, mem_request_address); end
    endtask

    task automatic test_jump_error(input logic [31:0] addr, input logic err);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        mem_request_ready = 1'b0;
        redirect_valid    = 1'b1;
        redirect_address  = addr;
        redirect_error    = err;
        tick;
        redirect_valid = 1'b0;
        redirect_error = 1'b0;
`ifdef FETCH_TRAP_EN
        total++; if (halted !== 1'b0 || mem_request_valid !== 1'b1 || mem_request_address !== 32'h100) begin bad++; $display("FAIL trap_%h halted=%b req=%b addr=%h exp 0/1/00000100", addr, halted, mem_request_valid, mem_request_address); end
`else
        total++; if (halted !== 1'b1 || mem_request_valid !== 1'b0 || instruction_valid !== 1'b0) begin bad++; $display("FAIL halt_%h halted=%b req=%b ivalid=%b exp 1/0/0", addr, halted, mem_request_valid, instruction_valid); end
        mem_request_ready  = 1'b1;
        redirect_valid     = 1'b1;
        redirect_address   = 32'h80;
        mem_response_valid = 1'b1;
        tick;
        redirect_valid     = 1'b0;
        mem_response_valid = 1'b0;
        tick;
        tick;
        total++; if (halted !== 1'b1 || mem_request_valid !== 1'b0 || instruction_valid !== 1'b0) begin bad++; $display("FAIL halt_sticky_%h halted=%b req=%b ivalid=%b exp 1/0/0", addr, halted, mem_request_valid, instruction_valid); end
`endif
        mem_request_ready = 1'b1;
    endtask

    task automatic test_reset_recover;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++; if (halted !== 1'b0 || mem_request_valid !== 1'b1 || mem_request_address !== 32'h0) begin bad++; $display("FAIL recover halted=%b req=%b addr=%h exp 0/1/00000000", halted, mem_request_valid, mem_request_address); end
    endtask

    initial begin
        #1;
        test_reset;
        test_sequential;
        test_redirect_wait;
        test_redirect_resp;
        test_stall;
        test_wrap;
        test_jump_error(32'h300, 1'b1);
        test_jump_error(32'h102, 1'b0);
        test_reset_recover;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
